// File: rtl/div_128by64_seq.sv
// div_128by64_seq: radix-2 restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock with valid/ready handshakes on both sides.
module div_128by64_seq #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, RUN = 2'd2, DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d, r_q, r_d, q_q, q_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] r_step, q_step;

    // R < D is invariant in RUN, so the subtraction never needs the carry bit
    assign t      = {r_q, q_q[WIDTH-1]};
    assign ge     = t >= {1'b0, d_q};
    assign r_step = ge ? WIDTH'(t - {1'b0, d_q}) : t[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                d_d     = divisor;
                r_d     = dividend[2*WIDTH-1:WIDTH];
                q_d     = dividend[WIDTH-1:0];
                state_d = CHECK;
            end
            CHECK: begin
                if (d_q == '0 || r_q >= d_q) begin
                    dbz_d   = d_q == '0;
                    ovf_d   = d_q != '0;
                    quo_d   = '1;
                    rem_d   = q_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_div_128by64_seq.sv
// tb_div_128by64_seq: directed vectors with hand-computed results for the sequential divider.
module tb_div_128by64_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] dividend = '0;
    logic [63:0]  divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  quotient, remainder;
    logic         div_by_zero, overflow;
    int           checks = 0;
    int           errors = 0;

    div_128by64_seq #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [127:0] a, input logic [63:0] b, input logic [63:0] eq,
                       input logic [63:0] er, input logic ez, input logic eo,
                       input int elat, input int hold);
        int n;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = hold == 0;
        check("ready_pre", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = '1;
        divisor  = 64'h5;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 200);
        check("latency", n, elat);
        check("busy", in_ready, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        check("overflow", overflow, eo);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_q", quotient, eq);
            check("hold_r", remainder, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
        check("post_q", quotient, eq);
    endtask

    initial begin
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(128'd100, 64'd7, 64'd14, 64'd2, 0, 0, 65, 0);
        run(128'hFFFFFFFFFFFFFFFE_0000000000000001, 64'hFFFFFFFFFFFFFFFF,
            64'hFFFFFFFFFFFFFFFF, 64'd0, 0, 0, 65, 0);
        run(128'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1234, 1, 0, 1, 0);
        run(128'h1_0000000000000000, 64'd1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 0, 1, 1, 0);
        run(128'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'd1, 64'h7FFFFFFFFFFFFFFF, 0, 0, 65, 0);
        run(128'd0, 64'd5, 64'd0, 64'd0, 0, 0, 65, 0);
        run(128'h6_0000000000000000, 64'd7, 64'hDB6DB6DB6DB6DB6D, 64'd5, 0, 0, 65, 0);
        run(128'd1000, 64'd3, 64'd333, 64'd1, 0, 0, 65, 10);
        @(negedge clk);
        dividend = 128'd1000;
        divisor  = 64'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(128'd100, 64'd7, 64'd14, 64'd2, 0, 0, 65, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
